// File: rtl/stream_average_calc_if.sv
// stream_average_calc_if: sample input and result output handshakes for stream_average_calc
//   in_valid/in_data/in_ready : producer -> block sample stream
//   avg_valid/avg_data/avg_ready : block -> consumer result
interface stream_average_calc_if #(
  parameter int DATA_W = 8
) ();
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              avg_valid;
  logic [DATA_W-1:0] avg_data;
  logic              avg_ready;
  modport slave (input in_valid, in_data, avg_ready, output in_ready, avg_valid, avg_data);
  modport master (output in_valid, in_data, avg_ready, input in_ready, avg_valid, avg_data);
endinterface

// File: rtl/stream_average_calc.sv
// stream_average_calc: averages 2^LOG2_N unsigned samples per start, truncating or rounding half up
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : begin a run (IDLE, or OUT together with result take)
//   clear      : synchronous abort back to IDLE, result discarded
//   busy       : high outside IDLE
//   s          : sample input and result output handshakes
module stream_average_calc #(
  parameter int DATA_W = 8,
  parameter int LOG2_N = 2,
  parameter int ROUND  = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   clear,
  output logic                   busy,
  stream_average_calc_if.slave   s
);
  localparam int N  = 2 ** LOG2_N;
  localparam int AW = DATA_W + LOG2_N;
  localparam int CW = LOG2_N > 0 ? LOG2_N : 1;
  // Half an LSB of the result; N/2 is 0 when N=1, so no add in that case.
  localparam int RC = ROUND != 0 ? N / 2 : 0;
  typedef enum logic [1:0] {IDLE, ACC, DIV, OUT} state_t;
  state_t            state_q, state_d;
  logic [AW-1:0]     acc_q, acc_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] avg_q, avg_d;
  logic [AW-1:0]     rounded;
  logic              last;
  assign rounded     = acc_q + AW'(RC);
  assign last        = cnt_q == CW'(N - 1);
  assign s.in_ready  = state_q == ACC;
  assign s.avg_valid = state_q == OUT;
  assign s.avg_data  = avg_q;
  assign busy        = state_q != IDLE;
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    avg_d   = avg_q;
    if (clear) begin
      state_d = IDLE;
      acc_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          state_d = ACC;
          acc_d   = '0;
          cnt_d   = '0;
        end
        ACC: if (s.in_valid) begin
          acc_d   = acc_q + AW'(s.in_data);
          cnt_d   = cnt_q + CW'(1);
          state_d = last ? DIV : ACC;
        end
        DIV: begin
          avg_d   = DATA_W'(rounded >> LOG2_N);
          state_d = OUT;
        end
        OUT: if (s.avg_ready) begin
          state_d = start ? ACC : IDLE;
          acc_d   = '0;
          cnt_d   = '0;
        end
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      avg_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      avg_q   <= avg_d;
    end
  end
endmodule
